fpga_config_loader: RTL
=======================

Name: fpga_config_loader

Overview:
Upstream configuration stage for the `fpga` fabric. It accepts a serial-beat bitstream over a valid/ready interface and assembles it in a shadow register. After verifying an XOR checksum, it commits the bitstream atomically to the parallel `sramConfig`/`cbconfig`/`sconfig` vectors that drive the fabric. It also holds the fabric in reset until a valid configuration is committed.

Parameters:
- DATA_W, 4, bits per beat; must divide 804 (legal values: 1, 2, 3, 4, 6, 12).
- TOTAL_BITS, 804, payload length. Fixed as 144 + 420 + 240; not to be overridden.

Ports:
- clk  in  1  fabric clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_start  in  1  single-cycle pulse that begins a new load.
- cfg_valid  in  1  beat valid.
- cfg_data  in  DATA_W  beat payload.
- cfg_ready  out  1  loader can accept a beat.
- sramConfig  out  144  committed LUT SRAM configuration.
- cbconfig  out  420  committed connection-box configuration.
- sconfig  out  240  committed switch-box configuration.
- cfg_done  out  1  a valid configuration is committed (level).
- cfg_error  out  1  the last load failed its checksum (level).
- fabric_reset  out  1  active-high hold for the fabric; deasserted only after commit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; beat counter, running XOR and shadow all cleared.
  - sramConfig, cbconfig and sconfig = 0.
  - cfg_ready=0, cfg_done=0, cfg_error=0, fabric_reset=1.
- Bit order:
  - Payload vector P = {sramConfig, cbconfig, sconfig}; P[803] is the MSB.
  - Beats arrive MSB-first: beat k carries P[803-k*DATA_W -: DATA_W], with cfg_data[DATA_W-1] as the more significant bit.
  - 804/DATA_W payload beats are followed by 1 checksum beat.
- Transfer rule:
  - A beat is accepted on a rising edge where cfg_valid & cfg_ready.
  - cfg_data is don't-care when cfg_valid=0.
  - cfg_ready is a registered state decode: 1 in LOAD and CHECK, 0 in IDLE and COMMIT.
- States:
  - IDLE: on cfg_start, go to LOAD. Clear the counter and XOR, set cfg_done=0, cfg_error=0, fabric_reset=1. The committed outputs hold their old values.
  - LOAD: each accepted beat is shifted into the shadow, XORed into the running checksum, and the counter increments. When beat number 804/DATA_W-1 is accepted, go to CHECK.
  - CHECK: the next accepted beat is compared with the running XOR.
    - Equal: go to COMMIT.
    - Unequal: go to IDLE, set cfg_error=1. Outputs stay unchanged and fabric_reset stays 1.
  - COMMIT: one cycle only. On its closing edge, copy the shadow to the three outputs, set cfg_done=1 and fabric_reset=0, then go to IDLE.
- Latency: the committed outputs, cfg_done and fabric_reset change exactly 2 edges after the checksum beat is accepted (E = acceptance edge, E+1 enters COMMIT, E+2 updates).
- Boundary conditions:
  - cfg_start in LOAD or CHECK: abort and restart. Counter and XOR are cleared; a beat presented in the same cycle is discarded. Outputs and fabric_reset are unaffected (fabric_reset is already 1).
  - cfg_start in COMMIT: ignored; the commit completes.
  - cfg_start in the same cycle as entering IDLE from COMMIT: takes effect the next cycle if it is still asserted. cfg_start is a pulse, so the source must re-issue it.
  - cfg_valid with cfg_ready=0: no effect; no beat is lost or counted.
  - Reset mid-load: full reset values apply immediately, including zeroed config outputs.
  - Stalls of any length (cfg_valid=0) are tolerated; the counter and shadow hold.
  - The counter never wraps: the CHECK transition is exact at the final payload beat.
- Checksum: bitwise XOR over all payload beats, DATA_W bits wide, with an initial value of 0.

Test Plan:
1. Load, DATA_W=4:
   - Stimulus: after reset release, pulse cfg_start, then stream 201 beats of the 4-bit adder image (sram 0x9696_9696_E8E8_9696_9696_0000_E8E8_E8E8_E8E8, followed by the matching cbconfig/sconfig), then the correct XOR beat.
   - Required: 2 edges after the checksum beat, the outputs equal the image, cfg_done=1 and fabric_reset=0. The first four beats are 9, 6, 9, 6.
2. Bad checksum:
   - Stimulus: the same stream with the checksum beat XORed with 4'h1.
   - Required: cfg_error=1, cfg_done=0, fabric_reset=1, and the outputs still hold their prior values (0 after reset).
3. Stalls:
   - Stimulus: random cfg_valid gaps of 0–7 cycles throughout case 1.
   - Required: the result is identical to case 1; the beat count is exactly 202 accepted beats.
4. Abort and restart:
   - Stimulus: pulse cfg_start after 50 beats, then send a full valid stream.
   - Required: the commit equals the second stream, with no residue from the first 50 beats.
5. Reset mid-load:
   - Stimulus: assert reset=0 after 100 beats of a second load that follows a successful one.
   - Required: the outputs immediately read 0, cfg_done=0, fabric_reset=1, cfg_ready=0.
6. Reload:
   - Stimulus: after a committed image A, load image B.
   - Required: A stays on the outputs with fabric_reset=1 during the load; B appears atomically at commit.

Source files
------------

// File: rtl/fpga_config_loader_if.sv
// Beat-stream handshake between a bitstream source and fpga_config_loader.
// The master drives start/valid/data; the loader (slave) returns ready.
interface fpga_config_loader_if #(
  parameter int DATA_W = 4
) ();
  logic              cfg_start;
  logic              cfg_valid;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_ready;

  modport master (
    output cfg_start, cfg_valid, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/fpga_config_loader.sv
// Serial bitstream loader: assembles an 804-bit image MSB-first in a shadow register,
// verifies an XOR checksum beat and commits the image atomically to the fabric.
module fpga_config_loader #(
  parameter int DATA_W     = 4,
  parameter int TOTAL_BITS = 804
) (
  input  logic                 clk,
  input  logic                 reset,
  fpga_config_loader_if.slave  cfg,
  output logic [143:0]         sramConfig,
  output logic [419:0]         cbconfig,
  output logic [239:0]         sconfig,
  output logic                 cfg_done,
  output logic                 cfg_error,
  output logic                 fabric_reset
);

  localparam int NBEATS = TOTAL_BITS / DATA_W;
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  // VERIFY holds the registered checksum beat for one cycle so the commit lands
  // exactly two edges after the checksum beat is accepted.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    VERIFY = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t                  state_q,  state_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [DATA_W-1:0]       xor_q,    xor_d;
  logic [DATA_W-1:0]       chk_q,    chk_d;
  logic [TOTAL_BITS-1:0]   shadow_q, shadow_d;
  logic [143:0]            sram_q,   sram_d;
  logic [419:0]            cb_q,     cb_d;
  logic [239:0]            sb_q,     sb_d;
  logic                    ready_q,  ready_d;
  logic                    done_q,   done_d;
  logic                    error_q,  error_d;
  logic                    frst_q,   frst_d;

  logic              accept;
  logic              start;
  logic [DATA_W-1:0] beat;

  assign start  = cfg.cfg_start;
  assign beat   = cfg.cfg_data;
  assign accept = cfg.cfg_valid & ready_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    chk_d    = chk_q;
    shadow_d = shadow_q;
    sram_d   = sram_q;
    cb_d     = cb_q;
    sb_d     = sb_q;
    done_d   = done_q;
    error_d  = error_q;
    frst_d   = frst_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          xor_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          frst_d  = 1'b1;
        end
      end
      LOAD: begin
        if (start) begin
          cnt_d = '0;
          xor_d = '0;
        end else if (accept) begin
          shadow_d = {shadow_q[TOTAL_BITS-DATA_W-1:0], beat};
          xor_d    = xor_q ^ beat;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = CHECK;
        end
      end
      CHECK: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          xor_d   = '0;
        end else if (accept) begin
          chk_d   = beat;
          state_d = VERIFY;
        end
      end
      VERIFY: begin
        if (chk_q == xor_q) begin
          state_d = COMMIT;
        end else begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      COMMIT: begin
        sram_d  = shadow_q[TOTAL_BITS-1 -: 144];
        cb_d    = shadow_q[TOTAL_BITS-145 -: 420];
        sb_d    = shadow_q[239:0];
        done_d  = 1'b1;
        frst_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD) || (state_d == CHECK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shadow is reset along with the control state so a reset mid-load
      // never leaves stale payload that a later partial stream could commit.
      state_q  <= IDLE;
      cnt_q    <= '0;
      xor_q    <= '0;
      chk_q    <= '0;
      shadow_q <= '0;
      sram_q   <= '0;
      cb_q     <= '0;
      sb_q     <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      frst_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      chk_q    <= chk_d;
      shadow_q <= shadow_d;
      sram_q   <= sram_d;
      cb_q     <= cb_d;
      sb_q     <= sb_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      error_q  <= error_d;
      frst_q   <= frst_d;
    end
  end

  assign cfg.cfg_ready  = ready_q;
  assign sramConfig     = sram_q;
  assign cbconfig       = cb_q;
  assign sconfig        = sb_q;
  assign cfg_done       = done_q;
  assign cfg_error      = error_q;
  assign fabric_reset   = frst_q;

endmodule
